// File: rtl/card_shoe.sv
// Finite-deck card source: tracks per-rank counts over NUM_DECKS decks and deals one
// card per draw request, falling back to a linear scan when RNG samples keep missing.
module card_shoe #(
  parameter int NUM_DECKS    = 1,
  parameter int MAX_TRIES    = 8,
  parameter int RESHUFFLE_AT = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rng_value,
  input  logic       draw_req,
  input  logic       shuffle_req,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [3:0] card_value,
  output logic       busy,
  output logic [7:0] cards_left,
  output logic       low_shoe,
  output logic       empty_err
);

  localparam logic [4:0] FULL_RANK = 5'(4 * NUM_DECKS);
  localparam logic [7:0] FULL_SHOE = 8'(52 * NUM_DECKS);
  localparam logic [7:0] LOW_MARK  = 8'(RESHUFFLE_AT);
  localparam logic [3:0] LAST_TRY  = 4'(MAX_TRIES - 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, SCAN, GRANT, SHUFFLE} state_t;

  state_t     state, state_next;
  logic [4:0] rank_cnt [1:13];
  logic [3:0] rank_r, scan_idx, shuf_idx, tries;
  logic       draw_pend, shuf_pend;

  logic       eff_draw, eff_shuf, start_shuf, start_draw, draw_empty;
  logic       sample_ok, scan_ok, take, last_try;
  logic [3:0] take_rank;

  // Pending requests share the IDLE decision with fresh ones; shuffle always wins.
  always_comb begin
    eff_draw   = draw_req | draw_pend;
    eff_shuf   = shuffle_req | shuf_pend;
    start_shuf = (state == IDLE) && eff_shuf;
    start_draw = (state == IDLE) && !eff_shuf && eff_draw && (cards_left != 8'd0);
    draw_empty = (state == IDLE) && !eff_shuf && eff_draw && (cards_left == 8'd0);
    sample_ok  = 1'b0;
    if (rank_r >= 4'd1 && rank_r <= 4'd13)
      sample_ok = (rank_cnt[rank_r] != 5'd0);
    scan_ok    = (rank_cnt[scan_idx] != 5'd0);
    last_try   = (tries == LAST_TRY);
    take       = ((state == CHECK) && sample_ok) || ((state == SCAN) && scan_ok);
    take_rank  = (state == CHECK) ? rank_r : scan_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_shuf) state_next = SHUFFLE;
               else if (start_draw) state_next = SAMPLE;
      SAMPLE:  state_next = CHECK;
      CHECK:   if (sample_ok) state_next = GRANT;
               else if (last_try) state_next = SCAN;
               else state_next = SAMPLE;
      SCAN:    if (scan_ok) state_next = GRANT;
      GRANT:   state_next = IDLE;
      SHUFFLE: if (shuf_idx == 4'd13) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    card_valid = (state == GRANT);
    busy       = (state != IDLE);
    low_shoe   = (cards_left <= LOW_MARK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= 13; i++) rank_cnt[i] <= FULL_RANK;
      cards_left <= FULL_SHOE;
      rank_r     <= 4'd0;
      scan_idx   <= 4'd1;
      shuf_idx   <= 4'd1;
      tries      <= 4'd0;
      draw_pend  <= 1'b0;
      shuf_pend  <= 1'b0;
      card_rank  <= 4'd0;
      card_value <= 4'd0;
      empty_err  <= 1'b0;
    end else begin
      empty_err <= draw_empty;

      if (start_draw) tries <= 4'd0;
      if (state == SAMPLE) rank_r <= rng_value;
      if (state == CHECK && !sample_ok) tries <= tries + 4'd1;

      if (state == CHECK) scan_idx <= 4'd1;
      else if (state == SCAN && !scan_ok) scan_idx <= scan_idx + 4'd1;

      if (take) begin
        rank_cnt[take_rank] <= rank_cnt[take_rank] - 5'd1;
        cards_left          <= cards_left - 8'd1;
        card_rank           <= take_rank;
        card_value          <= (take_rank >= 4'd10) ? 4'd10 : take_rank;
      end

      // Reload one rank per cycle; the shoe total only becomes full on the final rank.
      if (state == SHUFFLE) begin
        rank_cnt[shuf_idx] <= FULL_RANK;
        if (shuf_idx == 4'd13) begin
          shuf_idx   <= 4'd1;
          cards_left <= FULL_SHOE;
        end else begin
          shuf_idx <= shuf_idx + 4'd1;
        end
      end

      if (state == IDLE) begin
        if (start_shuf) begin
          shuf_pend <= 1'b0;
          draw_pend <= draw_pend | draw_req;
        end else if (eff_draw) begin
          draw_pend <= draw_pend & draw_req;
        end
      end else begin
        draw_pend <= draw_pend | draw_req;
        if (state != SHUFFLE) shuf_pend <= shuf_pend | shuffle_req;
      end
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: directed steps plus randomized held-RNG draws,
// checked against a per-rank card-count model of the shoe.
module tb_card_shoe;

  localparam int MAX_TRIES = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rng_value = 4'd0;
  logic       draw_req = 1'b0;
  logic       shuffle_req = 1'b0;
  logic       card_valid;
  logic [3:0] card_rank, card_value;
  logic       busy, low_shoe, empty_err;
  logic [7:0] cards_left;

  int checks = 0;
  int errors = 0;
  int model_cnt [1:13];
  int model_left;

  card_shoe #(.NUM_DECKS(1), .MAX_TRIES(MAX_TRIES), .RESHUFFLE_AT(12)) dut (
    .clk(clk), .rst_n(rst_n), .rng_value(rng_value), .draw_req(draw_req),
    .shuffle_req(shuffle_req), .card_valid(card_valid), .card_rank(card_rank),
    .card_value(card_value), .busy(busy), .cards_left(cards_left),
    .low_shoe(low_shoe), .empty_err(empty_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 1; r <= 13; r++) model_cnt[r] = 4;
    model_left = 52;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One draw with rng_value held; the model decides which rank and how many cycles.
  task automatic apply_stimulus(input logic [3:0] v);
    int exp_rank, exp_lat, cyc;
    exp_rank = 0;
    if (v >= 1 && v <= 13 && model_cnt[v] > 0) begin
      exp_rank = v;
      exp_lat  = 3;
    end else begin
      for (int r = 13; r >= 1; r--) if (model_cnt[r] > 0) exp_rank = r;
      exp_lat = 2 * MAX_TRIES + 1 + exp_rank;
    end
    rng_value = v;
    draw_req  = 1'b1;
    step();
    draw_req = 1'b0;
    cyc = 1;
    while (card_valid !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    check_output("draw_latency", cyc, exp_lat);
    check_output("card_rank", card_rank, exp_rank);
    check_output("card_value", card_value, (exp_rank >= 10) ? 10 : exp_rank);
    model_cnt[exp_rank]--;
    model_left--;
    check_output("cards_left", cards_left, model_left);
    check_output("low_shoe", low_shoe, (model_left <= 12) ? 1 : 0);
    step();
    check_output("valid_one_cycle", card_valid, 0);
    check_output("idle_after_grant", busy, 0);
  endtask

  initial begin
    int cyc;
    $display("[TB] start");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", card_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_left", cards_left, 52);
    check_output("reset_rank", card_rank, 0);
    check_output("reset_value", card_value, 0);
    check_output("reset_low", low_shoe, 0);
    check_output("reset_empty", empty_err, 0);
    rst_n = 1'b1;
    step();

    apply_stimulus(4'd7);
    for (int i = 0; i < 5; i++) apply_stimulus(4'd12);
    apply_stimulus(4'd0);
    apply_stimulus(4'd14);

    $display("[TB] random draws until the shoe is empty");
    while (model_left > 0) apply_stimulus(4'($urandom_range(0, 15)));

    draw_req = 1'b1;
    step();
    draw_req = 1'b0;
    check_output("empty_err_pulse", empty_err, 1);
    check_output("empty_busy", busy, 0);
    step();
    check_output("empty_err_clear", empty_err, 0);
    check_output("empty_no_valid", card_valid, 0);
    check_output("empty_left", cards_left, 0);
    check_output("empty_low", low_shoe, 1);

    shuffle_req = 1'b1;
    step();
    shuffle_req = 1'b0;
    check_output("shuffle_busy_start", busy, 1);
    repeat (12) step();
    check_output("shuffle_busy_end", busy, 1);
    step();
    check_output("shuffle_done_idle", busy, 0);
    check_output("shuffle_left", cards_left, 52);
    check_output("shuffle_low", low_shoe, 0);
    model_reset();

    // Draw and shuffle together: shuffle first, then the latched draw.
    rng_value   = 4'd5;
    draw_req    = 1'b1;
    shuffle_req = 1'b1;
    step();
    draw_req    = 1'b0;
    shuffle_req = 1'b0;
    cyc = 1;
    while (card_valid !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    check_output("pend_draw_latency", cyc, 17);
    check_output("pend_draw_rank", card_rank, 5);
    model_cnt[5]--;
    model_left--;
    check_output("pend_draw_left", cards_left, model_left);
    step();
    check_output("pend_valid_clear", card_valid, 0);

    // Reset asserted while the draw is in CHECK.
    rng_value = 4'd9;
    draw_req  = 1'b1;
    step();
    draw_req = 1'b0;
    step();
    check_output("busy_in_check", busy, 1);
    rst_n = 1'b0;
    step();
    check_output("rst_mid_valid", card_valid, 0);
    check_output("rst_mid_busy", busy, 0);
    check_output("rst_mid_left", cards_left, 52);
    check_output("rst_mid_rank", card_rank, 0);
    rst_n = 1'b1;
    model_reset();
    step();
    apply_stimulus(4'd9);
    apply_stimulus(4'($urandom_range(1, 13)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
